// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states, iteration count and sign helper for muldiv_seq
package muldiv_pkg;
  localparam int ITERATIONS = 32;
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
    return (s & v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/adder32bit.sv
// adder32bit: 32-bit ripple-carry adder
module adder32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  // carry ripples bit by bit from i_cin to o_cout
  always_comb begin
    logic c;
    o_sum = '0;
    c = i_cin;
    for (int i = 0; i < 32; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-cycle shift-add multiplier / restoring divider; divide built only with MULDIV_DIV_EN
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err
);
  state_e      r_state, w_state_nxt;
  op_e         r_op;
  logic [31:0] r_a, r_b, r_m, r_acc, r_q, r_hi, r_lo;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_err;
  logic [31:0] w_add_a, w_add_b, w_sum;
  logic        w_cin, w_cout, w_is_div, w_signed, w_short;
  logic [63:0] w_prod, w_fix;
  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_prod   = {r_acc, r_q};
  assign w_fix    = r_neg_q ? -w_prod : w_prod;
`ifdef MULDIV_DIV_EN
  logic r_neg_r, w_ok;
  assign w_add_a = w_is_div ? {r_acc[30:0], r_q[31]} : r_acc;
  assign w_add_b = w_is_div ? ~r_m : (r_q[0] ? r_m : '0);
  assign w_cin   = w_is_div;
  assign w_ok    = r_acc[31] | w_cout;
  assign w_short = w_is_div && r_b == '0;
`else
  assign w_add_a = r_acc;
  assign w_add_b = r_q[0] ? r_m : '0;
  assign w_cin   = 1'b0;
  assign w_short = w_is_div;
`endif
  adder32bit u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (w_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign err  = r_err;
  // next-state: divide-by-zero / unsupported divide skips straight from PREP to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_PREP : S_IDLE;
      S_PREP:  w_state_nxt = w_short ? S_DONE : S_RUN;
      S_RUN:   w_state_nxt = (r_cnt == 5'(ITERATIONS - 1)) ? S_FIX : S_RUN;
      S_FIX:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // state, datapath and result registers; results only change on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_r <= 1'b0;
`endif
      r_hi    <= '0;
      r_lo    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_op <= op_e'(op);
          r_a  <= a;
          r_b  <= b;
        end
        S_PREP: begin
          r_cnt   <= '0;
          r_acc   <= '0;
          r_neg_q <= w_signed & (r_a[31] ^ r_b[31]);
`ifdef MULDIV_DIV_EN
          r_neg_r <= w_signed & r_a[31];
          r_m     <= mag32(w_is_div ? r_b : r_a, w_signed);
          r_q     <= mag32(w_is_div ? r_a : r_b, w_signed);
          if (w_short) begin
            r_hi  <= r_a;
            r_lo  <= '1;
            r_err <= 1'b1;
          end
`else
          r_m     <= mag32(r_a, w_signed);
          r_q     <= mag32(r_b, w_signed);
          if (w_short) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_err <= 1'b1;
          end
`endif
        end
        S_RUN: begin
          r_cnt <= r_cnt + 5'd1;
`ifdef MULDIV_DIV_EN
          r_acc <= w_is_div ? (w_ok ? w_sum : w_add_a) : {w_cout, w_sum[31:1]};
          r_q   <= w_is_div ? {r_q[30:0], w_ok} : {w_sum[0], r_q[31:1]};
`else
          r_acc <= {w_cout, w_sum[31:1]};
          r_q   <= {w_sum[0], r_q[31:1]};
`endif
        end
        S_FIX: begin
`ifdef MULDIV_DIV_EN
          r_hi <= w_is_div ? (r_neg_r ? -r_acc : r_acc) : w_fix[63:32];
          r_lo <= w_is_div ? (r_neg_q ? -r_q : r_q) : w_fix[31:0];
`else
          {r_hi, r_lo} <= w_fix;
`endif
          r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus corner-case sequences for muldiv_seq
module tb_muldiv_seq;
  import muldiv_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, err;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vecs[15];
  muldiv_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo),
    .err  (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, nd, first, second;
    logic hold;
    logic [31:0] prev_hi, prev_lo, rhi, rlo;
    vec_t v;
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
    vecs[1]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 2};
    vecs[2]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
    vecs[3]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35};
    vecs[4]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 35};
    vecs[5]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35};
    vecs[6]  = '{OP_MULT,  32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0, 35};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
    vecs[9]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
    vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 35};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 35};
    vecs[12] = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2};
    vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 35};
    vecs[14] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 35};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, err, hi, lo}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
`ifndef MULDIV_DIV_EN
      if (v.op[1]) begin
        v.hi = '0;
        v.lo = '0;
        v.err = 1'b1;
        v.lat = 2;
      end
`endif
      launch(v.op, v.a, v.b);
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      lat = 1;
      hold = 1'b1;
      while (!done && lat < 80) begin
        if (hi !== prev_hi || lo !== prev_lo) hold = 1'b0;
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, v.lat);
      chk($sformatf("v%0d_hold", i), hold, 1'b1);
      chk($sformatf("v%0d_result", i), {v.err, v.hi, v.lo}, {err, hi, lo});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_after", i), {busy, done}, 2'b00);
      chk($sformatf("v%0d_held", i), {err, hi, lo}, {v.err, v.hi, v.lo});
      prev_hi = v.hi;
      prev_lo = v.lo;
    end
    // start pulsed mid-operation must be dropped
    launch(OP_MULTU, 32'd3, 32'd5);
    nd = 0;
    first = 0;
    rhi = '1;
    rlo = '1;
    for (lat = 1; lat <= 45; lat++) begin
      if (done) begin
        nd++;
        if (first == 0) first = lat;
        rhi = hi;
        rlo = lo;
      end
      start = (lat == 10);
      if (lat == 10) begin
        op = OP_MULT;
        a = 32'd9;
        b = 32'd9;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("busy_ignore_count", nd, 1);
    chk("busy_ignore_latency", first, 35);
    chk("busy_ignore_result", {rhi, rlo}, {32'd0, 32'd15});
    // start held high: ignored in DONE, accepted in the following IDLE cycle
    launch(OP_MULTU, 32'd2, 32'd3);
    start = 1'b1;
    nd = 0;
    first = 0;
    second = 0;
    for (lat = 1; lat <= 75; lat++) begin
      if (done) begin
        nd++;
        if (first == 0) first = lat;
        else second = lat;
        rlo = lo;
      end
      start = (lat < 37);
      @(posedge clk);
      #1;
    end
    chk("held_start_count", nd, 2);
    chk("held_start_first", first, 35);
    chk("held_start_second", second, 71);
    chk("held_start_lo", rlo, 32'd6);
    // reset mid-operation clears everything and suppresses done
`ifdef MULDIV_DIV_EN
    launch(OP_DIVU, 32'd100, 32'd7);
`else
    launch(OP_MULTU, 32'd100, 32'd7);
`endif
    for (lat = 1; lat < 20; lat++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset_state", {busy, done, err, hi, lo}, '0);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      if (done) nd++;
      @(posedge clk);
      #1;
    end
    chk("mid_reset_no_done", nd, 0);
    launch(OP_MULTU, 32'd2, 32'd2);
    lat = 1;
    while (!done && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("post_reset_latency", lat, 35);
    chk("post_reset_result", {err, hi, lo}, {1'b0, 32'd0, 32'd4});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, iteration count fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-006 a  input  32  multiplicand / dividend; captured on accepted start.
REQ-007 b  input  32  multiplier / divisor; captured on accepted start.
REQ-008 busy  output  1  high from cycle after accepted start through the DONE cycle.
REQ-009 done  output  1  one-cycle pulse; hi/lo/err valid in that cycle.
REQ-010 hi  output  32  product upper word / remainder.
REQ-011 lo  output  32  product lower word / quotient.
REQ-012 err  output  1  divide-by-zero or unsupported op; valid with done, held with results.

Function
REQ-013 FSM states SHALL be IDLE, PREP, RUN, FIX, DONE.
REQ-014 IDLE: start=1 accepted (cycle N) -> PREP; operands and op captured; start=0 -> stay IDLE.
REQ-015 PREP: signed ops take operand magnitudes and record result signs; iteration counter cleared -> RUN.
REQ-016 RUN: exactly 32 cycles; one shift-add (multiply) or one restoring shift-subtract (divide) per cycle -> FIX.
REQ-017 FIX: signed ops negate results per recorded signs -> DONE.
REQ-018 DONE: done=1 for one cycle, busy=1 -> IDLE.
REQ-019 Normal latency: done high in cycle N+35.
REQ-020 All RUN-state add/subtract SHALL pass through one shared 32-bit ripple adder instance (subtract = inverted operand, c_in=1); PREP/FIX sign logic may be separate.
REQ-021 Multiply: {hi,lo} = full 64-bit product; MULT signed, MULTU unsigned.
REQ-022 Divide: lo=quotient truncated toward zero, hi=remainder with sign of dividend; DIV signed, DIVU unsigned.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, err=0.
REQ-024 Divide with b=0: PREP -> DONE directly, done in cycle N+2, hi=a, lo=0xFFFFFFFF, err=1.
REQ-025 start while busy=1 SHALL be ignored, no queuing.
REQ-026 hi/lo/err SHALL hold their values until the DONE cycle of the next accepted operation; intermediate values never appear on hi/lo.
REQ-027 start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.

Reset
REQ-028 rst_n=0 at any clock edge, including mid-operation: state=IDLE, busy=0, done=0, err=0, hi=0, lo=0, counter=0.
REQ-029 Operation interrupted by reset SHALL produce no done pulse.

Configuration
REQ-030 Macro MULDIV_DIV_EN: defined -> DIV/DIVU implemented per REQ-022..024.
REQ-031 MULDIV_DIV_EN undefined -> no divide logic; op 2/3 accepted, done in cycle N+2, hi=0, lo=0, err=1.

Structure
REQ-032 Shared package muldiv_pkg: op encodings, FSM state encoding, ITERATIONS=32 constant.
REQ-033 Single sub-module: existing 32-bit ripple adder adder32bit, instantiated once; no other sub-modules.

Verification
REQ-034 MULT a=0xFFFFFFFD(-3) b=7 -> done at N+35, hi=0xFFFFFFFF, lo=0xFFFFFFEB, err=0.
REQ-035 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 -> done at N+2, hi=100, lo=0xFFFFFFFF, err=1.
REQ-037 MULTU 3*5 started, start pulsed with other operands at N+10 -> single done at N+35, lo=15, hi=0.
REQ-038 rst_n=0 at N+20 of DIVU -> busy=0, hi=lo=0 next cycle, no done; new MULTU 2*2 afterwards -> lo=4.
